// File: rtl/frame_stream_source.sv
// Frame-buffer reader: on start, reads one IMG_WIDTH x IMG_HEIGHT frame in raster order from a
// 1-cycle-latency RAM and emits it as a valid/ready pixel stream with sof/eol/eof markers.
module frame_stream_source #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int ADDR_W     = (IMG_WIDTH * IMG_HEIGHT > 1) ? $clog2(IMG_WIDTH * IMG_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_sof,
  output logic              y_eol,
  output logic              y_eof,
  output logic [1:0]        dbg_state
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int EW    = W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic [COL_W-1:0]    col_q;
  logic                inflight_q;
  logic [2:0]          infl_flags_q;
  logic [EW-1:0]       fifo_q [2];
  logic [1:0]          count_q;
  logic                done_q;

  logic                fifo_nonempty;
  logic [EW-1:0]       head;
  logic [EW-1:0]       new_entry;
  logic                pop;
  logic                pop_fifo;
  logic                push;
  logic [1:0]          wr_idx;
  logic [1:0]          count_d;
  logic [2:0]          occ;
  logic                issue;

  // Stream handshake: a beat transfers on every cycle with y_valid & y_ready; once y_valid is high
  // the beat (data and flags) holds until accepted. The read still in flight acts as the youngest
  // queue entry, so its data is presented straight from the RAM when the FIFO is empty.
  always_comb begin
    fifo_nonempty = (count_q != 2'd0);
    new_entry     = {mem_rd_data, infl_flags_q};
    head          = '0;
    if (fifo_nonempty) begin
      head = fifo_q[0];
    end else if (inflight_q) begin
      head = new_entry;
    end
    y_valid  = fifo_nonempty | inflight_q;
    {y_data, y_sof, y_eol, y_eof} = head;
    pop      = y_valid & y_ready;
    pop_fifo = pop & fifo_nonempty;
    push     = inflight_q & ~(pop & ~fifo_nonempty);
    wr_idx   = count_q - {1'b0, pop_fifo};
    count_d  = count_q + {1'b0, push} - {1'b0, pop_fifo};
    // Occupancy after this cycle's pop; a new read is only issued if it will have a slot.
    occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state_q == S_READ) && (occ < 3'd2);
  end

  assign mem_rd_en = issue;
  assign mem_addr  = rd_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      col_q        <= '0;
      inflight_q   <= 1'b0;
      infl_flags_q <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      count_q    <= count_d;

      if (issue) begin
        infl_flags_q <= {rd_cnt_q == '0, col_q == LAST_COL, rd_cnt_q == LAST_ADDR};
        if (rd_cnt_q != LAST_ADDR) rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
        col_q <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
      end

      if (pop_fifo) fifo_q[0] <= fifo_q[1];
      if (push) begin
        if (wr_idx == 2'd0) fifo_q[0] <= new_entry;
        else                fifo_q[1] <= new_entry;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_READ;
            rd_cnt_q <= '0;
            col_q    <= '0;
          end
        end
        S_READ: begin
          if (issue && rd_cnt_q == LAST_ADDR) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The eof beat can only be the last one out, so its acceptance closes the frame.
          if (pop && y_eof) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: three instances (320x240, 8x4, 1x1) share clock and reset;
// one is driven at a time and its stream is scored against a per-frame expected beat list.
module tb_frame_stream_source;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s [3];
  logic        ready_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        rd_en_s [3];
  logic        valid_s [3];
  logic        sof_s   [3];
  logic        eol_s   [3];
  logic        eof_s   [3];
  logic [1:0]  st_s    [3];
  logic [7:0]  data_s  [3];
  logic [7:0]  rd_data_s [3];
  logic [16:0] addr_s  [3];
  logic [16:0] a0;
  logic [4:0]  a1;
  logic [0:0]  a2;

  assign addr_s[0] = a0;
  assign addr_s[1] = {12'd0, a1};
  assign addr_s[2] = {16'd0, a2};

  frame_stream_source #(.IMG_WIDTH(320), .IMG_HEIGHT(240), .W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .mem_rd_en(rd_en_s[0]), .mem_addr(a0), .mem_rd_data(rd_data_s[0]),
    .y_valid(valid_s[0]), .y_ready(ready_s[0]), .y_data(data_s[0]),
    .y_sof(sof_s[0]), .y_eol(eol_s[0]), .y_eof(eof_s[0]), .dbg_state(st_s[0]));

  frame_stream_source #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .mem_rd_en(rd_en_s[1]), .mem_addr(a1), .mem_rd_data(rd_data_s[1]),
    .y_valid(valid_s[1]), .y_ready(ready_s[1]), .y_data(data_s[1]),
    .y_sof(sof_s[1]), .y_eol(eol_s[1]), .y_eof(eof_s[1]), .dbg_state(st_s[1]));

  frame_stream_source #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .W(8)) u2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .mem_rd_en(rd_en_s[2]), .mem_addr(a2), .mem_rd_data(rd_data_s[2]),
    .y_valid(valid_s[2]), .y_ready(ready_s[2]), .y_data(data_s[2]),
    .y_sof(sof_s[2]), .y_eol(eol_s[2]), .y_eof(eof_s[2]), .dbg_state(st_s[2]));

  int npix [3] = '{76800, 32, 1};
  int wid  [3] = '{320, 8, 1};

  logic [7:0] ram1 [32];
  logic [7:0] ram2;

  function automatic logic [7:0] ram_val(input int i, input int a);
    if (i == 0) return a[7:0];
    if (i == 1) return ram1[a];
    return ram2;
  endfunction

  // RAM model: data only meaningful the cycle after a read; otherwise the bus carries junk.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      rd_data_s[i] <= rd_en_s[i] ? ram_val(i, int'(addr_s[i])) : 8'($urandom);
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [10:0] exp_q[$];
  int cur = 0;
  int cyc = 0;
  int t0 = 0;
  int issued, outstanding, beats, n_sof, n_eol, n_eof, n_done, done_rel, first_rel, busy_rise;
  logic prev_busy = 1'b0;
  logic stalled = 1'b0;
  logic eof_acc = 1'b0;
  logic [10:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [10:0] beat;
    logic        pop;
    eof_acc = 1'b0;
    if (rst) begin
      outstanding = 0;
      stalled     = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      pop  = valid_s[cur] && ready_s[cur];
      beat = {data_s[cur], sof_s[cur], eol_s[cur], eof_s[cur]};
      if (stalled) begin
        chk("stall_valid", 32'(valid_s[cur]), 32'd1);
        chk("stall_hold", 32'(beat), 32'(held));
      end
      stalled = valid_s[cur] && !ready_s[cur];
      held    = beat;
      if (valid_s[cur] && first_rel < 0) first_rel = cyc - t0;
      if (rd_en_s[cur]) begin
        chk("rd_addr", 32'(addr_s[cur]), 32'(issued));
        chk("credit", 32'((outstanding - int'(pop)) < 2), 32'd1);
        issued++;
        outstanding++;
      end
      if (pop) begin
        outstanding--;
        beats++;
        n_sof += int'(sof_s[cur]);
        n_eol += int'(eol_s[cur]);
        n_eof += int'(eof_s[cur]);
        if (eof_s[cur]) eof_acc = 1'b1;
        if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 32'd1);
        else chk("beat", 32'(beat), 32'(exp_q.pop_front()));
      end
      if (done_s[cur]) begin
        n_done++;
        done_rel = cyc - t0;
      end
      if (busy_s[cur] && !prev_busy) busy_rise++;
      prev_busy = busy_s[cur];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input int i);
    cur = i;
    issued = 0; outstanding = 0; beats = 0;
    n_sof = 0; n_eol = 0; n_eof = 0;
    n_done = 0; done_rel = -1; first_rel = -1; busy_rise = 0;
    exp_q.delete();
  endtask

  task automatic load_frame(input int i, input int limit);
    for (int k = 0; k < npix[i] && k < limit; k++)
      exp_q.push_back({ram_val(i, k), k == 0, (k % wid[i]) == wid[i] - 1, k == npix[i] - 1});
  endtask

  task automatic start_frame(input int i);
    start_s[i] = 1'b1;
    t0 = cyc;
    tick();
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int pct_low);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      if (pct_low > 0) ready_s[cur] = ($urandom_range(0, 99) >= pct_low);
      tick();
      k++;
    end
    if (n_done == 0) chk("done_timeout", 32'(n_done), 32'd1);
    ready_s[cur] = 1'b1;
  endtask

  task automatic chk_idle(input int i);
    chk($sformatf("rst_outs%0d", i),
        {busy_s[i], done_s[i], rd_en_s[i], valid_s[i], sof_s[i], eol_s[i], eof_s[i],
         data_s[i], addr_s[i]}, 32'd0);
  endtask

  initial begin
    int rd_seen;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) ram1[i] = 8'($urandom);
    ram2 = 8'($urandom);
    clear_stats(0);

    // 1. reset then idle
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk_idle(i);
    rd_seen = 0;
    repeat (100) begin
      tick();
      for (int i = 0; i < 3; i++) rd_seen += int'(rd_en_s[i]);
    end
    chk("idle_rd_en", 32'(rd_seen), 32'd0);

    // 2. full 320x240 frame, no backpressure
    clear_stats(0);
    load_frame(0, 76800);
    ready_s[0] = 1'b1;
    start_frame(0);
    wait_done(77000, 0);
    chk("full_first", 32'(first_rel), 32'd2);
    chk("full_beats", 32'(beats), 32'd76800);
    chk("full_sof", 32'(n_sof), 32'd1);
    chk("full_eol", 32'(n_eol), 32'd240);
    chk("full_eof", 32'(n_eof), 32'd1);
    chk("full_done_cyc", 32'(done_rel), 32'd76802);
    chk("full_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk("full_busy", 32'(busy_s[0]), 32'd0);

    // 3. 8x4 frame with ~30% backpressure
    clear_stats(1);
    load_frame(1, 32);
    ready_s[1] = 1'b0;
    start_frame(1);
    wait_done(2000, 30);
    chk("bp_beats", 32'(beats), 32'd32);
    chk("bp_eol", 32'(n_eol), 32'd4);
    chk("bp_sof_eof", 32'({n_sof[3:0], n_eof[3:0]}), 32'h11);
    chk("bp_left", 32'(exp_q.size()), 32'd0);
    chk("bp_done", 32'(n_done), 32'd1);

    // 4. start held high through the whole frame, including the final-handshake edge
    repeat (3) tick();
    clear_stats(1);
    load_frame(1, 32);
    start_s[1] = 1'b1;
    t0 = cyc;
    k = 0;
    while (!eof_acc && k < 2000) begin
      ready_s[1] = ($urandom_range(0, 99) >= 30);
      tick();
      k++;
    end
    start_s[1] = 1'b0;
    ready_s[1] = 1'b1;
    wait_done(20, 0);
    repeat (10) tick();
    chk("hold_done", 32'(n_done), 32'd1);
    chk("hold_busy_rise", 32'(busy_rise), 32'd1);
    chk("hold_beats", 32'(beats), 32'd32);
    chk("hold_reads", 32'(issued), 32'd32);
    chk("hold_busy_after", 32'(busy_s[1]), 32'd0);
    // second frame only on a fresh start in idle
    clear_stats(1);
    load_frame(1, 32);
    start_frame(1);
    wait_done(100, 0);
    chk("again_beats", 32'(beats), 32'd32);
    chk("again_done_cyc", 32'(done_rel), 32'd34);

    // 5. reset mid-frame at beat 100
    clear_stats(0);
    load_frame(0, 200);
    ready_s[0] = 1'b1;
    start_frame(0);
    k = 0;
    while (beats < 100 && k < 300) begin
      tick();
      k++;
    end
    chk("mid_reach100", 32'(beats), 32'd100);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("mid_no_done", 32'(n_done), 32'd0);
    chk_idle(0);
    clear_stats(0);
    load_frame(0, 64);
    start_frame(0);
    repeat (40) tick();
    chk("mid_restart_first", 32'(first_rel), 32'd2);
    chk("mid_restart_sof", 32'(n_sof), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 6. 1x1 frame, first plain then with a stall on the only beat
    clear_stats(2);
    load_frame(2, 1);
    ready_s[2] = 1'b1;
    start_frame(2);
    wait_done(10, 0);
    chk("one_first", 32'(first_rel), 32'd2);
    chk("one_flags", 32'({n_sof[3:0], n_eol[3:0], n_eof[3:0]}), 32'h111);
    chk("one_done_cyc", 32'(done_rel), 32'd3);
    repeat (2) tick();
    ram2 = 8'($urandom);
    clear_stats(2);
    load_frame(2, 1);
    ready_s[2] = 1'b0;
    start_frame(2);
    repeat (3) tick();
    ready_s[2] = 1'b1;
    wait_done(10, 0);
    chk("one_stall_beats", 32'(beats), 32'd1);
    chk("one_stall_done_cyc", 32'(done_rel), 32'd5);
    chk("one_stall_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
